dmem_port: RTL and testbench

// - Responder side of the MEM-stage stall handshake. Produces dmem_wait for the hazard unit.
// - Converts MEM-stage load/store requests (RV32I funct3 sizes) into word-aligned

---
 rtl/dmem_port.sv | 220 ++++++++++++++++++++++
 tb/tb_dmem_port.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port.sv
// dmem_port: MEM-stage data memory port.
// Turns a load/store held in the MEM stage into one word-aligned valid/ready
// bus transaction. It stalls the pipeline until the result exists, then keeps
// that result stable until the pipeline advances.
module dmem_port #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    input  logic        pipe_enable,
    output logic        dmem_wait,
    output logic [31:0] load_data,
    output logic        access_fault,
    output logic        bus_error,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LAST = TIMEOUT_EN ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    // Illegal funct3 codes, or a halfword/word that is not naturally aligned.
    function automatic logic size_fault(input logic [2:0] size, input logic [1:0] addr_lo);
        logic f;
        case (size)
            3'b000, 3'b100: f = 1'b0;
            3'b001, 3'b101: f = addr_lo[0];
            3'b010:         f = (addr_lo != 2'b00);
            default:        f = 1'b1;
        endcase
        return f;
    endfunction

    // Byte strobes for a store of the given size at the given lane.
    function automatic logic [3:0] lane_strb(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] s;
        case (size[1:0])
            2'b00:   s = 4'b0001 << addr_lo;
            2'b01:   s = 4'b0011 << addr_lo;
            2'b10:   s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Store data replicated across every lane it could land in.
    function automatic logic [31:0] lane_wdata(input logic [2:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size[1:0])
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            2'b10:   d = wdata;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    // Pick the addressed byte/halfword out of the bus word and extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                                input logic [1:0]  addr_lo,
                                                input logic [2:0]  size);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {addr_lo, 3'b000};
        case (size)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b010:  r = rdata;
            3'b100:  r = {24'h00_0000, sh[7:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t        state_r;
    logic [31:0]   addr_r;
    logic [1:0]    addr_lo_r;
    logic [31:0]   wdata_r;
    logic [3:0]    strb_r;
    logic          we_r;
    logic [2:0]    size_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   load_data_r;
    logic          bus_error_r;

    logic          req_active_s;
    logic          fault_s;
    logic          dmem_wait_s;
    logic          access_fault_s;

    assign req_active_s = req_read | req_write;
    assign fault_s      = size_fault(req_size, req_addr[1:0]);

    // Stall request and fault flag; both drop immediately while reset is held.
    always_comb begin
        dmem_wait_s    = 1'b0;
        access_fault_s = 1'b0;
        if (rst) begin
            dmem_wait_s    = 1'b0;
            access_fault_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_active_s) begin
                        dmem_wait_s    = ~fault_s;
                        access_fault_s = fault_s;
                    end else begin
                        dmem_wait_s    = 1'b0;
                        access_fault_s = 1'b0;
                    end
                end
                ST_ISSUE: dmem_wait_s = 1'b1;
                ST_RESP:  dmem_wait_s = 1'b1;
                ST_HOLD:  dmem_wait_s = 1'b0;
                default:  dmem_wait_s = 1'b0;
            endcase
        end
    end

    // Transaction FSM: capture request, drive the bus, collect and hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            addr_r      <= 32'h0000_0000;
            addr_lo_r   <= 2'b00;
            wdata_r     <= 32'h0000_0000;
            strb_r      <= 4'b0000;
            we_r        <= 1'b0;
            size_r      <= 3'b000;
            cnt_r       <= {CW{1'b0}};
            load_data_r <= 32'h0000_0000;
            bus_error_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_active_s && !fault_s) begin
                        addr_r      <= {req_addr[31:2], 2'b00};
                        addr_lo_r   <= req_addr[1:0];
                        size_r      <= req_size;
                        we_r        <= req_write;
                        wdata_r     <= req_write ? lane_wdata(req_size, req_wdata) : 32'h0000_0000;
                        strb_r      <= req_write ? lane_strb(req_size, req_addr[1:0]) : 4'b0000;
                        cnt_r       <= {CW{1'b0}};
                        load_data_r <= 32'h0000_0000;
                        bus_error_r <= 1'b0;
                        state_r     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus_ready) begin
                        if (we_r) begin
                            state_r <= ST_HOLD;
                        end else if (bus_rvalid) begin
                            load_data_r <= load_extend(bus_rdata, addr_lo_r, size_r);
                            state_r     <= ST_HOLD;
                        end else begin
                            state_r <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (bus_rvalid) begin
                        load_data_r <= load_extend(bus_rdata, addr_lo_r, size_r);
                        state_r     <= ST_HOLD;
                    end else if (TIMEOUT_EN && (cnt_r == CNT_LAST)) begin
                        load_data_r <= 32'h0000_0000;
                        bus_error_r <= 1'b1;
                        state_r     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Result stays put until the pipeline consumes it; no re-issue here.
                    if (pipe_enable) begin
                        load_data_r <= 32'h0000_0000;
                        bus_error_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // State is asynchronously reset, so bus_valid falls as soon as rst rises.
    assign bus_valid    = (state_r == ST_ISSUE);
    assign bus_we       = we_r;
    assign bus_addr     = addr_r;
    assign bus_wdata    = wdata_r;
    assign bus_wstrb    = strb_r;
    assign load_data    = load_data_r;
    assign bus_error    = bus_error_r;
    assign dmem_wait    = dmem_wait_s;
    assign access_fault = access_fault_s;

endmodule

// File: tb/tb_dmem_port.sv
// Testbench for dmem_port: scoreboard of expected load results, two instances
// (default timeout and a short 4-cycle timeout) fed the same stimulus.
module tb_dmem_port;

    logic        clk;
    logic        rst;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        pipe_enable;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    logic        dmem_wait, access_fault, bus_error, bus_valid, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;

    logic        to_dmem_wait, to_access_fault, to_bus_error, to_bus_valid, to_bus_we;
    logic [31:0] to_load_data, to_bus_addr, to_bus_wdata;
    logic [3:0]  to_bus_wstrb;

    dmem_port u_dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .pipe_enable(pipe_enable),
        .dmem_wait(dmem_wait), .load_data(load_data), .access_fault(access_fault),
        .bus_error(bus_error), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    dmem_port #(.TIMEOUT_CYCLES(4)) u_dut_to (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .pipe_enable(pipe_enable),
        .dmem_wait(to_dmem_wait), .load_data(to_load_data), .access_fault(to_access_fault),
        .bus_error(to_bus_error), .bus_valid(to_bus_valid), .bus_ready(bus_ready),
        .bus_we(to_bus_we), .bus_addr(to_bus_addr), .bus_wdata(to_bus_wdata),
        .bus_wstrb(to_bus_wstrb), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   tx_cnt   = 0;

    // Count accepted bus handshakes on the default instance.
    always @(posedge clk) begin
        if (bus_valid && bus_ready) tx_cnt <= tx_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] got_data, input logic got_err);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_data"}, got_data, e.data);
            check_eq({tag, "_err"}, {31'd0, got_err}, {31'd0, e.err});
        end
    endtask

    // One access on the default instance; called at a cycle start with the DUT idle.
    task automatic run_access(input string tag, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] size,
                              input int ready_dly, input int rv_dly, input logic [31:0] rdata,
                              input logic [31:0] exp_data, input logic [3:0] exp_strb,
                              input logic [31:0] exp_bwdata, input int hold_cycles);
        exp_t e;
        int   nvalid;
        req_read  = ~wr;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        pipe_enable = 1'b0;
        e.data = exp_data;
        e.err  = 1'b0;
        exp_q.push_back(e);
        #1;
        check_eq({tag, "_idle_wait"}, {31'd0, dmem_wait}, 32'd1);
        check_eq({tag, "_idle_valid"}, {31'd0, bus_valid}, 32'd0);
        tick();
        nvalid = 0;
        for (int i = 0; i <= ready_dly; i++) begin
            bus_ready = (i == ready_dly);
            if ((i == ready_dly) && !wr && (rv_dly == 0)) begin
                bus_rvalid = 1'b1;
                bus_rdata  = rdata;
            end
            #1;
            if (bus_valid) nvalid++;
            check_eq({tag, "_iss_wait"}, {31'd0, dmem_wait}, 32'd1);
            check_eq({tag, "_addr"}, bus_addr, {addr[31:2], 2'b00});
            check_eq({tag, "_we"}, {31'd0, bus_we}, {31'd0, wr});
            check_eq({tag, "_wstrb"}, {28'd0, bus_wstrb}, {28'd0, exp_strb});
            if (wr) check_eq({tag, "_wdata"}, bus_wdata, exp_bwdata);
            tick();
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
        end
        check_eq({tag, "_valid_cycles"}, nvalid, ready_dly + 1);
        if (!wr && rv_dly > 0) begin
            for (int j = 1; j <= rv_dly; j++) begin
                if (j == rv_dly) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rdata;
                end
                #1;
                check_eq({tag, "_resp_wait"}, {31'd0, dmem_wait}, 32'd1);
                check_eq({tag, "_resp_valid"}, {31'd0, bus_valid}, 32'd0);
                tick();
                bus_rvalid = 1'b0;
            end
        end
        for (int h = 0; h < hold_cycles; h++) begin
            pipe_enable = (h == hold_cycles - 1);
            #1;
            check_eq({tag, "_hold_wait"}, {31'd0, dmem_wait}, 32'd0);
            check_eq({tag, "_hold_valid"}, {31'd0, bus_valid}, 32'd0);
            if (h == 0) pop_check(tag, load_data, bus_error);
            else check_eq({tag, "_hold_data"}, load_data, exp_data);
            tick();
        end
        pipe_enable = 1'b0;
        req_read    = 1'b0;
        req_write   = 1'b0;
        #1;
        check_eq({tag, "_clr_data"}, load_data, 32'd0);
        check_eq({tag, "_clr_wait"}, {31'd0, dmem_wait}, 32'd0);
        tick();
    endtask

    initial begin
        int tx0;
        exp_t e;
        rst = 1'b1;
        req_read = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req_size = 3'b000; pipe_enable = 1'b0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        tick();
        tick();
        check_eq("rst_wait", {31'd0, dmem_wait}, 32'd0);
        check_eq("rst_valid", {31'd0, bus_valid}, 32'd0);
        check_eq("rst_data", load_data, 32'd0);
        check_eq("rst_err", {31'd0, bus_error}, 32'd0);
        check_eq("rst_addr", bus_addr, 32'd0);
        check_eq("rst_strb", {28'd0, bus_wstrb}, 32'd0);
        rst = 1'b0;
        tick();

        // Zero-wait loads: signed and unsigned byte from lane 3.
        run_access("lb", 1'b0, 32'h0000_0103, 32'd0, 3'b000, 0, 0, 32'h80FF_0000,
                   32'hFFFF_FF80, 4'b0000, 32'd0, 1);
        run_access("lbu", 1'b0, 32'h0000_0103, 32'd0, 3'b100, 0, 0, 32'h80FF_0000,
                   32'h0000_0080, 4'b0000, 32'd0, 1);

        // Halfword store with ready after three waiting cycles.
        run_access("sh", 1'b1, 32'h0000_0202, 32'h1234_ABCD, 3'b001, 3, 0, 32'd0,
                   32'h0000_0000, 4'b1100, 32'hABCD_ABCD, 1);
        run_access("sb", 1'b1, 32'h0000_0201, 32'h0000_005A, 3'b000, 0, 0, 32'd0,
                   32'h0000_0000, 4'b0010, 32'h5A5A_5A5A, 1);

        // Faulting requests: no stall, no bus activity.
        req_read = 1'b1; req_addr = 32'h0000_0301; req_size = 3'b010;
        #1;
        check_eq("lw_mis_fault", {31'd0, access_fault}, 32'd1);
        check_eq("lw_mis_wait", {31'd0, dmem_wait}, 32'd0);
        tick();
        tick();
        check_eq("lw_mis_valid", {31'd0, bus_valid}, 32'd0);
        check_eq("lw_mis_data", load_data, 32'd0);
        req_addr = 32'h0000_0300; req_size = 3'b011;
        #1;
        check_eq("sz011_fault", {31'd0, access_fault}, 32'd1);
        check_eq("sz011_wait", {31'd0, dmem_wait}, 32'd0);
        tick();
        check_eq("sz011_valid", {31'd0, bus_valid}, 32'd0);
        req_read = 1'b0;
        #1;
        check_eq("nofault_idle", {31'd0, access_fault}, 32'd0);
        tick();

        // Word load, late response, result held across a frozen pipeline.
        tx0 = tx_cnt;
        run_access("lw_hold", 1'b0, 32'h0000_0300, 32'd0, 3'b010, 0, 5, 32'hDEAD_BEEF,
                   32'hDEAD_BEEF, 4'b0000, 32'd0, 4);
        check_eq("lw_hold_tx", tx_cnt - tx0, 32'd1);

        // Timeout on the short-timeout instance; late rvalid in HOLD is ignored.
        req_read = 1'b1; req_addr = 32'h0000_0400; req_size = 3'b010;
        e.data = 32'd0;
        e.err  = 1'b1;
        exp_q.push_back(e);
        #1;
        check_eq("to_idle_wait", {31'd0, to_dmem_wait}, 32'd1);
        tick();
        bus_ready = 1'b1;
        #1;
        check_eq("to_iss_valid", {31'd0, to_bus_valid}, 32'd1);
        tick();
        bus_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            check_eq("to_resp_wait", {31'd0, to_dmem_wait}, 32'd1);
            tick();
        end
        #1;
        check_eq("to_hold_wait", {31'd0, to_dmem_wait}, 32'd0);
        pop_check("to", to_load_data, to_bus_error);
        tick();
        bus_rvalid = 1'b1; bus_rdata = 32'h0000_0055;
        tick();
        bus_rvalid = 1'b0;
        #1;
        check_eq("to_late_data", to_load_data, 32'd0);
        check_eq("to_late_err", {31'd0, to_bus_error}, 32'd1);
        check_eq("to_late_wait", {31'd0, to_dmem_wait}, 32'd0);
        pipe_enable = 1'b1;
        tick();
        pipe_enable = 1'b0;
        req_read = 1'b0;
        #1;
        check_eq("to_clr_err", {31'd0, to_bus_error}, 32'd0);
        check_eq("to_main_wait", {31'd0, dmem_wait}, 32'd0);
        tick();

        // Reset in ISSUE; stale rvalid afterwards is ignored.
        req_read = 1'b1; req_addr = 32'h0000_0500; req_size = 3'b010;
        tick();
        #1;
        check_eq("rst_iss_valid", {31'd0, bus_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_async_valid", {31'd0, bus_valid}, 32'd0);
        check_eq("rst_async_wait", {31'd0, dmem_wait}, 32'd0);
        req_read = 1'b0;
        tick();
        rst = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_0000;
        tick();
        bus_rvalid = 1'b0;
        #1;
        check_eq("stale_data", load_data, 32'd0);
        check_eq("stale_wait", {31'd0, dmem_wait}, 32'd0);
        check_eq("stale_valid", {31'd0, bus_valid}, 32'd0);
        tick();

        // Signed halfword from the upper lane after recovery.
        run_access("lh", 1'b0, 32'h0000_0502, 32'd0, 3'b001, 1, 2, 32'h8001_0000,
                   32'hFFFF_8001, 4'b0000, 32'd0, 1);
        run_access("lhu", 1'b0, 32'h0000_0500, 32'd0, 3'b101, 0, 0, 32'h1234_F00D,
                   32'h0000_F00D, 4'b0000, 32'd0, 1);

        check_eq("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
